// File: rtl/fb_pkg.sv
// Shared constants and pixel types for the frame-buffer port arbiter.
package fb_pkg;

  localparam int unsigned H_ACTIVE  = 800;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FB_WORDS  = H_ACTIVE * V_ACTIVE;

  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned FB_DATA_W = 16;
  localparam int unsigned STALL_W   = 16;

  localparam int unsigned R_W = 5;
  localparam int unsigned G_W = 6;
  localparam int unsigned B_W = 5;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Display-read, host-write and RAM-side signals of the frame-buffer arbiter.
interface fb_port_arbiter_if
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W
);

  logic               disp_rd;
  logic [ADDR_W-1:0]  disp_addr;
  logic [DATA_W-1:0]  disp_data;
  logic               disp_vld;
  logic               wr_valid;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_ready;
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic [STALL_W-1:0] wr_stall_cnt;

  // Arbiter side
  modport slave (
    input  disp_rd, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_vld, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
           wr_stall_cnt
  );

  // Requesters and RAM side
  modport master (
    output disp_rd, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_vld, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
           wr_stall_cnt
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO holding {addr,data} entries; no bypass from push to head.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned W     = FB_ADDR_W + FB_DATA_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, posted host
// writes drain on idle cycles; 2-cycle read pipeline and write-stall counter.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned DATA_W     = FB_DATA_W,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fb_port_arbiter_if.slave bus
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic               rd_vld_q,    rd_vld_d;
  logic               disp_vld_q,  disp_vld_d;
  logic [DATA_W-1:0]  disp_data_q, disp_data_d;
  logic [STALL_W-1:0] stall_q,     stall_d;

  assign bus.wr_ready = rst & ~fifo_full;
  assign fifo_push    = bus.wr_valid & bus.wr_ready;
  assign {head_addr, head_data} = fifo_head;

  fb_wr_fifo #(
    .W     (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   ({bus.wr_addr, bus.wr_data}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // RAM port mux: display read, else drain FIFO head, else idle
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    fifo_pop      = 1'b0;
    if (rst) begin
      if (bus.disp_rd) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_addr;
      end else if (!fifo_empty) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = head_addr;
        bus.mem_wdata = head_data;
        fifo_pop      = 1'b1;
      end
    end
  end

  always_comb begin
    rd_vld_d    = bus.disp_rd;
    disp_vld_d  = rd_vld_q;
    disp_data_d = rd_vld_q ? bus.mem_rdata : disp_data_q;
    stall_d     = stall_q;
    if (bus.wr_valid && !bus.wr_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_vld_q    <= 1'b0;
      disp_vld_q  <= 1'b0;
      disp_data_q <= '0;
      stall_q     <= '0;
    end else begin
      rd_vld_q    <= rd_vld_d;
      disp_vld_q  <= disp_vld_d;
      disp_data_q <= disp_data_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.disp_vld     = disp_vld_q;
  assign bus.disp_data    = disp_data_q;
  assign bus.wr_stall_cnt = stall_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port RAM.
module tb_fb_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_port_arbiter_if bus ();

  fb_port_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] ram [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  // RAM with one-cycle read latency, plus a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    if (bus.mem_en && bus.mem_we)  ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [18:0] raddr,
                       input logic wv, input logic [18:0] waddr, input logic [15:0] wdata);
    @(negedge clk);
    rst           = r;
    bus.disp_rd   = rd;
    bus.disp_addr = raddr;
    bus.wr_valid  = wv;
    bus.wr_addr   = waddr;
    bus.wr_data   = wdata;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rd;
    logic [18:0] raddr;
    logic        wv;
    logic [18:0] waddr;
    logic [15:0] wdata;
    logic        e_rdy;
    logic        e_en;
    logic        e_we;
    logic [18:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_vld;
    logic [15:0] e_data;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vt [12];

  initial begin
    // reset, read latency, write drain then read-back
    vt[0]  = '{1'b0, 1'b1, 19'h10, 1'b1, 19'h1, 16'h1111, 1'b0, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'h0,    16'h0};
    vt[1]  = '{1'b0, 1'b1, 19'h10, 1'b1, 19'h1, 16'h1111, 1'b0, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'h0,    16'h0};
    vt[2]  = '{1'b0, 1'b1, 19'h10, 1'b1, 19'h1, 16'h1111, 1'b0, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'h0,    16'h0};
    vt[3]  = '{1'b1, 1'b1, 19'h10, 1'b0, 19'h0, 16'h0,    1'b1, 1'b1, 1'b0, 19'h10, 16'h0,    1'b0, 16'h0,    16'h0};
    vt[4]  = '{1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0,    1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'h0,    16'h0};
    vt[5]  = '{1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0,    1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b1, 16'hF800, 16'h0};
    vt[6]  = '{1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0,    1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'hF800, 16'h0};
    vt[7]  = '{1'b1, 1'b0, 19'h0,  1'b1, 19'h5, 16'h07E0, 1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'hF800, 16'h0};
    vt[8]  = '{1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0,    1'b1, 1'b1, 1'b1, 19'h5,  16'h07E0, 1'b0, 16'hF800, 16'h0};
    vt[9]  = '{1'b1, 1'b1, 19'h5,  1'b0, 19'h0, 16'h0,    1'b1, 1'b1, 1'b0, 19'h5,  16'h0,    1'b0, 16'hF800, 16'h0};
    vt[10] = '{1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0,    1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b0, 16'hF800, 16'h0};
    vt[11] = '{1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0,    1'b1, 1'b0, 1'b0, 19'h0,  16'h0,    1'b1, 16'h07E0, 16'h0};

    rst           = 1'b0;
    bus.disp_rd   = 1'b1;
    bus.disp_addr = 19'h10;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 19'h1;
    bus.wr_data   = 16'h1111;
    pre_we        = 1'b1;
    pre_addr      = 8'h10;
    pre_data      = 16'hF800;
    @(negedge clk);
    pre_addr = 8'h70;
    pre_data = 16'h1234;
    @(negedge clk);
    pre_we = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rst, vt[i].rd, vt[i].raddr, vt[i].wv, vt[i].waddr, vt[i].wdata);
      chk($sformatf("v%0d.wr_ready", i),  32'(bus.wr_ready),     32'(vt[i].e_rdy));
      chk($sformatf("v%0d.mem_en", i),    32'(bus.mem_en),       32'(vt[i].e_en));
      chk($sformatf("v%0d.mem_we", i),    32'(bus.mem_we),       32'(vt[i].e_we));
      chk($sformatf("v%0d.mem_addr", i),  32'(bus.mem_addr),     32'(vt[i].e_addr));
      chk($sformatf("v%0d.mem_wdata", i), 32'(bus.mem_wdata),    32'(vt[i].e_wdata));
      chk($sformatf("v%0d.disp_vld", i),  32'(bus.disp_vld),     32'(vt[i].e_vld));
      chk($sformatf("v%0d.disp_data", i), 32'(bus.disp_data),    32'(vt[i].e_data));
      chk($sformatf("v%0d.stall", i),     32'(bus.wr_stall_cnt), 32'(vt[i].e_stall));
    end

    // Priority and full FIFO: display reads for 10 cycles, host offers writes
    for (int c = 0; c < 10; c++) begin
      int k;
      k = (c < 4) ? c : 4;
      drive(1'b1, 1'b1, 19'h20, 1'b1, 19'(32'h40 + k), 16'(32'hA000 + k));
      chk($sformatf("full%0d.wr_ready", c), 32'(bus.wr_ready), (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("full%0d.mem_en", c),   32'(bus.mem_en),   32'd1);
      chk($sformatf("full%0d.mem_we", c),   32'(bus.mem_we),   32'd0);
      chk($sformatf("full%0d.stall", c),    32'(bus.wr_stall_cnt), (c < 4) ? 32'd0 : 32'(c - 4));
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0);
      chk($sformatf("drain%0d.mem_we", c),    32'(bus.mem_we),    32'd1);
      chk($sformatf("drain%0d.mem_addr", c),  32'(bus.mem_addr),  32'h40 + 32'(c));
      chk($sformatf("drain%0d.mem_wdata", c), 32'(bus.mem_wdata), 32'hA000 + 32'(c));
      chk($sformatf("drain%0d.wr_ready", c),  32'(bus.wr_ready),  (c == 0) ? 32'd0 : 32'd1);
      chk($sformatf("drain%0d.stall", c),     32'(bus.wr_stall_cnt), 32'd6);
    end
    drive(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0);
    chk("drain_done.mem_en", 32'(bus.mem_en), 32'd0);

    // Simultaneous push and pop with two entries held
    drive(1'b1, 1'b1, 19'h20, 1'b1, 19'h60, 16'hB000);
    drive(1'b1, 1'b1, 19'h20, 1'b1, 19'h61, 16'hB001);
    for (int p = 0; p < 5; p++) begin
      drive(1'b1, 1'b0, 19'h0, 1'b1, 19'(32'h62 + p), 16'(32'hB002 + p));
      chk($sformatf("pp%0d.mem_we", p),    32'(bus.mem_we),    32'd1);
      chk($sformatf("pp%0d.mem_addr", p),  32'(bus.mem_addr),  32'h60 + 32'(p));
      chk($sformatf("pp%0d.mem_wdata", p), 32'(bus.mem_wdata), 32'hB000 + 32'(p));
      chk($sformatf("pp%0d.wr_ready", p),  32'(bus.wr_ready),  32'd1);
    end
    for (int p = 5; p < 7; p++) begin
      drive(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0);
      chk($sformatf("pp%0d.mem_we", p),   32'(bus.mem_we),   32'd1);
      chk($sformatf("pp%0d.mem_addr", p), 32'(bus.mem_addr), 32'h60 + 32'(p));
    end
    drive(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0);
    chk("pp_done.mem_en", 32'(bus.mem_en), 32'd0);

    // Reset while three writes are pending
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 19'h20, 1'b1, 19'(32'h70 + k), 16'(32'hC000 + k));
      chk($sformatf("rstq%0d.mem_we", k), 32'(bus.mem_we), 32'd0);
    end
    chk("rstq.stall_before", 32'(bus.wr_stall_cnt), 32'd6);
    drive(1'b0, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0);
    chk("rstq.in_reset.mem_en",   32'(bus.mem_en),   32'd0);
    chk("rstq.in_reset.wr_ready", 32'(bus.wr_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0);
      chk($sformatf("rstq_after%0d.mem_en", k),   32'(bus.mem_en),   32'd0);
      chk($sformatf("rstq_after%0d.mem_we", k),   32'(bus.mem_we),   32'd0);
      chk($sformatf("rstq_after%0d.wr_ready", k), 32'(bus.wr_ready), 32'd1);
      chk($sformatf("rstq_after%0d.stall", k),    32'(bus.wr_stall_cnt), 32'd0);
    end
    drive(1'b1, 1'b1, 19'h70, 1'b0, 19'h0, 16'h0);
    drive(1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0);
    drive(1'b1, 1'b0, 19'h0,  1'b0, 19'h0, 16'h0);
    chk("rstq.readback.vld",  32'(bus.disp_vld),  32'd1);
    chk("rstq.readback.data", 32'(bus.disp_data), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
